// File: rtl/eqn_eval_sweep.sv
`default_nettype none
// ============================================================================
// Module   : eqn_eval_sweep
// Brief    : Evaluates an N-input boolean function on a direct operand, or
//            sweeps every input vector 0..2**N-1 once while counting how many
//            of them make the function true.
// Revision : 1.0 - initial release
// ============================================================================
module eqn_eval_sweep #(
  parameter  int N    = 3,
  localparam int TT_W = 2**N
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode,
  input  logic [TT_W-1:0] tt_mask,
  input  logic [N-1:0]    in_vec,
  input  logic            start,
  output logic            y,
  output logic            y_valid,
  output logic [N-1:0]    vec_out,
  output logic [N:0]      ones_cnt,
  output logic            busy,
  output logic            done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [N-1:0] LAST_VEC = {N{1'b1}};

  logic [1:0]      state;
  logic            lat_fixed;    // function selection frozen for the whole sweep
  logic [TT_W-1:0] lat_mask;     // truth table frozen for the whole sweep
  logic [N-1:0]    vec_next;
  logic            fix_direct;
  logic            fix_next;
  logic            f_direct;
  logic            f_next;
  logic            f_zero;

  assign vec_next = vec_out + N'(1);

  // Fixed function: A AND (any lower input); a single-input equation is constant 0.
  if (N == 1) begin : g_fixed_n1
    assign fix_direct = 1'b0;
    assign fix_next   = 1'b0;
  end else begin : g_fixed_nx
    assign fix_direct = in_vec[N-1]   & (|in_vec[N-2:0]);
    assign fix_next   = vec_next[N-1] & (|vec_next[N-2:0]);
  end

  // Direct mode uses the live inputs; the sweep uses only the latched copies.
  assign f_direct = mode[0]   ? fix_direct : tt_mask[in_vec];
  assign f_next   = lat_fixed ? fix_next   : lat_mask[vec_next];
  // Fixed f(0) is always 0 because A is 0 at vector zero.
  assign f_zero   = mode[0]   ? 1'b0       : tt_mask[0];

  // Control FSM plus all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lat_fixed <= 1'b0;
      lat_mask  <= '0;
      y         <= 1'b0;
      y_valid   <= 1'b0;
      vec_out   <= '0;
      ones_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (!mode[1]) begin
            // Direct evaluation; start is deliberately ignored here.
            y       <= f_direct;
            vec_out <= in_vec;
            y_valid <= 1'b1;
          end else if (start) begin
            lat_fixed <= mode[0];
            lat_mask  <= tt_mask;
            vec_out   <= '0;
            y         <= f_zero;
            ones_cnt  <= (N+1)'(f_zero);
            y_valid   <= 1'b1;
            busy      <= 1'b1;
            state     <= S_SWEEP;
          end else begin
            y_valid <= 1'b0;
          end
        end

        S_SWEEP: begin
          if (vec_out == LAST_VEC) begin
            // Last vector already presented: results hold, pulse done.
            y_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            vec_out  <= vec_next;
            y        <= f_next;
            ones_cnt <= ones_cnt + (N+1)'(f_next);
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state   <= S_IDLE;
          y_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
